// File: rtl/ps2_command_scheduler_pkg.sv
// ps2_command_scheduler_pkg: shared FSM states, PS/2 opcodes/responses and error codes
package ps2_command_scheduler_pkg;
  typedef enum logic [2:0] {
    ST_IDLE, ST_SEND0, ST_WAIT0, ST_SEND1, ST_WAIT1, ST_FINISH, ST_ABORT
  } state_e;
  typedef enum logic [1:0] {
    ERR_NONE    = 2'b00,
    ERR_RETRY   = 2'b01,
    ERR_TIMEOUT = 2'b10
  } err_e;
  localparam logic [7:0] PS2_CMD_SET_LEDS = 8'hED;
  localparam logic [7:0] PS2_RSP_ACK      = 8'hFA;
  localparam logic [7:0] PS2_RSP_RESEND   = 8'hFE;
endpackage

// File: rtl/ps2_command_scheduler_if.sv
// ps2_command_scheduler_if: requester, transmitter, receiver and status signals of the scheduler
interface ps2_command_scheduler_if;
  logic       lock_req;
  logic [2:0] lock_bits;
  logic       cmd_req;
  logic [7:0] cmd_byte;
  logic       cmd_has_arg;
  logic [7:0] cmd_arg;
  logic       cmd_ack;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       tx_ready;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       busy;
  logic       done;
  logic       error;
  logic [1:0] err_code;
  logic [2:0] lock_state;
  modport master (
    output lock_req, lock_bits, cmd_req, cmd_byte, cmd_has_arg, cmd_arg, tx_ready, rx_valid, rx_data,
    input  cmd_ack, tx_valid, tx_data, busy, done, error, err_code, lock_state
  );
  modport slave (
    input  lock_req, lock_bits, cmd_req, cmd_byte, cmd_has_arg, cmd_arg, tx_ready, rx_valid, rx_data,
    output cmd_ack, tx_valid, tx_data, busy, done, error, err_code, lock_state
  );
endinterface

// File: rtl/ps2_timeout_timer.sv
// ps2_timeout_timer: counts enabled cycles and flags the last cycle of a TIMEOUT_CYCLES window
module ps2_timeout_timer #(
  parameter int TIMEOUT_CYCLES = 1_000_000,
  parameter int TO_W           = 20
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);
  logic [TO_W-1:0] cnt_q, cnt_d;
  assign cnt_d   = clear ? '0 : enable ? cnt_q + 1'b1 : cnt_q;
  assign expired = enable && cnt_q == TO_W'(TIMEOUT_CYCLES - 1);
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
endmodule

// File: rtl/ps2_command_scheduler.sv
// ps2_command_scheduler: arbitrates lock-LED and generic PS/2 commands, sends them byte by byte,
// waits for ACK, retries on RESEND and reports done/error.
module ps2_command_scheduler
  import ps2_command_scheduler_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1_000_000,
  parameter int MAX_RETRIES    = 3,
  parameter int TO_W           = 20
) (
  input logic                   clk,
  input logic                   reset,
  ps2_command_scheduler_if.slave bus
);
  localparam int RW = $clog2(MAX_RETRIES + 1);
  state_e          state_q, state_d;
  err_e            err_q, err_d;
  logic            pend_q, pend_d;
  logic [2:0]      pat_q, pat_d;
  logic            lock_txn_q, lock_txn_d;
  logic            two_q, two_d;
  logic [7:0]      b0_q, b0_d, b1_q, b1_d;
  logic [RW-1:0]   retry_q, retry_d;
  logic [2:0]      lock_state_q, lock_state_d;
  logic            ack_q, ack_d;
  logic            waiting, expired, grant_lock, grant_cmd, rx_ack, rx_resend;
  assign waiting    = state_q == ST_WAIT0 || state_q == ST_WAIT1;
  // lock_txn_q doubles as the round-robin last-grant flag
  assign grant_lock = state_q == ST_IDLE && pend_q && (!bus.cmd_req || !lock_txn_q);
  assign grant_cmd  = state_q == ST_IDLE && bus.cmd_req && !grant_lock;
  assign rx_ack     = bus.rx_valid && bus.rx_data == PS2_RSP_ACK;
  assign rx_resend  = bus.rx_valid && bus.rx_data == PS2_RSP_RESEND;
  ps2_timeout_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES), .TO_W(TO_W)) u_timer (
    .clk(clk), .rst(reset), .clear(!waiting), .enable(waiting), .expired(expired)
  );
  always_comb begin
    state_d      = state_q;
    pend_d       = bus.lock_req | (pend_q & ~grant_lock);
    pat_d        = bus.lock_req ? bus.lock_bits : pat_q;
    lock_txn_d   = lock_txn_q;
    two_d        = two_q;
    b0_d         = b0_q;
    b1_d         = b1_q;
    retry_d      = retry_q;
    err_d        = err_q;
    lock_state_d = lock_state_q;
    ack_d        = grant_cmd;
    unique case (state_q)
      ST_IDLE:
        if (grant_lock || grant_cmd) begin
          state_d    = ST_SEND0;
          lock_txn_d = grant_lock;
          b0_d       = grant_lock ? PS2_CMD_SET_LEDS : bus.cmd_byte;
          b1_d       = grant_lock ? {5'b0, pat_q} : bus.cmd_arg;
          two_d      = grant_lock | bus.cmd_has_arg;
          retry_d    = '0;
          err_d      = ERR_NONE;
        end
      ST_SEND0, ST_SEND1:
        if (bus.tx_ready) state_d = state_q == ST_SEND0 ? ST_WAIT0 : ST_WAIT1;
      ST_WAIT0, ST_WAIT1:
        if (rx_ack) begin
          retry_d = '0;
          state_d = (state_q == ST_WAIT0 && two_q) ? ST_SEND1 : ST_FINISH;
        end else if (rx_resend && retry_q < RW'(MAX_RETRIES)) begin
          retry_d = retry_q + 1'b1;
          state_d = state_q == ST_WAIT0 ? ST_SEND0 : ST_SEND1;
        end else if (rx_resend || expired) begin
          err_d   = rx_resend ? ERR_RETRY : ERR_TIMEOUT;
          state_d = ST_ABORT;
        end
      ST_FINISH: begin
        state_d      = ST_IDLE;
        lock_state_d = lock_txn_q ? b1_q[2:0] : lock_state_q;
      end
      default: state_d = ST_IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q      <= ST_IDLE;
      err_q        <= ERR_NONE;
      pend_q       <= 1'b0;
      pat_q        <= '0;
      lock_txn_q   <= 1'b0;
      two_q        <= 1'b0;
      b0_q         <= '0;
      b1_q         <= '0;
      retry_q      <= '0;
      lock_state_q <= '0;
      ack_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      err_q        <= err_d;
      pend_q       <= pend_d;
      pat_q        <= pat_d;
      lock_txn_q   <= lock_txn_d;
      two_q        <= two_d;
      b0_q         <= b0_d;
      b1_q         <= b1_d;
      retry_q      <= retry_d;
      lock_state_q <= lock_state_d;
      ack_q        <= ack_d;
    end
  assign bus.tx_valid   = state_q == ST_SEND0 || state_q == ST_SEND1;
  assign bus.tx_data    = state_q == ST_SEND1 ? b1_q : b0_q;
  assign bus.busy       = bus.tx_valid || waiting;
  assign bus.done       = state_q == ST_FINISH;
  assign bus.error      = state_q == ST_ABORT;
  assign bus.err_code   = err_q;
  assign bus.lock_state = lock_state_q;
  assign bus.cmd_ack    = ack_q;
endmodule

// File: tb/tb_ps2_command_scheduler.sv
// tb_ps2_command_scheduler: keyboard responder plus transaction-level model of expected bytes/outcomes
module tb_ps2_command_scheduler;
  localparam int MAXR = 3;
  logic clk = 1'b0;
  logic reset;
  ps2_command_scheduler_if bus ();
  ps2_command_scheduler #(.TIMEOUT_CYCLES(100), .MAX_RETRIES(MAXR), .TO_W(20)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );
  always #5 clk = ~clk;
  int vectors = 0, miscompares = 0;
  int last_lat, dones;
  bit fast, injected;
  logic [2:0] model_lock;
  logic [7:0] plan_q[$], sent_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // keyboard model: accepts offered bytes, answers each with the next planned reply (00 = silence)
  initial begin
    bit pend;
    int dly;
    logic [7:0] code;
    pend = 0; dly = 0; code = 8'h00;
    forever begin
      @(negedge clk);
      bus.rx_valid = 1'b0;
      bus.tx_ready = 1'b0;
      if (reset) pend = 0;
      else if (pend && dly > 0) begin
        dly--;
        if (!fast && $urandom_range(0, 1) == 1) begin bus.rx_valid = 1'b1; bus.rx_data = 8'h1C; end
      end else if (pend) begin
        pend = 0;
        if (code != 8'h00) begin bus.rx_valid = 1'b1; bus.rx_data = code; end
      end else if (bus.tx_valid && (fast || $urandom_range(0, 3) != 0)) begin
        bus.tx_ready = 1'b1;
        sent_q.push_back(bus.tx_data);
        code = plan_q.size() > 0 ? plan_q.pop_front() : 8'h00;
        pend = 1;
        dly = fast ? 0 : int'($urandom_range(0, 3));
      end
    end
  end

  task automatic run_txn(input bit is_lock, input logic [7:0] c0, input bit has_arg, input logic [7:0] arg,
                         input int nfe0, input bit sil0, input int nfe1, input bit sil1);
    logic [7:0] bytes [2];
    logic [7:0] exp_q[$];
    logic [2:0] exp_lock;
    int nb, n, exp_err, acks;
    bit s, got_done, got_err;
    bytes[0] = is_lock ? 8'hED : c0;
    bytes[1] = is_lock ? {5'b0, arg[2:0]} : arg;
    nb = (is_lock || has_arg) ? 2 : 1;
    exp_err = 0;
    plan_q.delete();
    sent_q.delete();
    for (int i = 0; i < nb && exp_err == 0; i++) begin
      n = i == 0 ? nfe0 : nfe1;
      s = i == 0 ? sil0 : sil1;
      for (int k = 0; k < n && k <= MAXR; k++) begin plan_q.push_back(8'hFE); exp_q.push_back(bytes[i]); end
      if (n > MAXR) exp_err = 1;
      else begin
        plan_q.push_back(s ? 8'h00 : 8'hFA);
        exp_q.push_back(bytes[i]);
        exp_err = s ? 2 : 0;
      end
    end
    exp_lock = (is_lock && exp_err == 0) ? arg[2:0] : model_lock;
    @(negedge clk);
    if (is_lock) begin bus.lock_req = 1'b1; bus.lock_bits = arg[2:0]; end
    else begin bus.cmd_req = 1'b1; bus.cmd_byte = c0; bus.cmd_has_arg = has_arg; bus.cmd_arg = arg; end
    got_done = 0; got_err = 0; acks = 0; last_lat = 0;
    for (int cyc = 1; cyc < 2000 && !(got_done || got_err); cyc++) begin
      @(negedge clk);
      bus.lock_req = 1'b0;
      if (bus.cmd_ack) begin acks++; bus.cmd_req = 1'b0; end
      got_done = bus.done;
      got_err = bus.error;
      last_lat = cyc;
    end
    bus.cmd_req = 1'b0;
    check("done", got_done, exp_err == 0);
    check("error", got_err, exp_err != 0);
    check("err_code", bus.err_code, exp_err);
    check("cmd_ack_count", acks, is_lock ? 0 : 1);
    check("sent_len", sent_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < sent_q.size(); i++) check("sent_byte", sent_q[i], exp_q[i]);
    @(negedge clk);
    check("busy_after", bus.busy, 0);
    check("err_code_held", bus.err_code, exp_err);
    check("lock_state", bus.lock_state, exp_lock);
    model_lock = exp_lock;
  endtask

  initial begin
    #20ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int txv;
    reset = 1'b1;
    bus.lock_req = 0; bus.lock_bits = 0; bus.cmd_req = 0; bus.cmd_byte = 0;
    bus.cmd_has_arg = 0; bus.cmd_arg = 0; bus.tx_ready = 0; bus.rx_valid = 0; bus.rx_data = 0;
    fast = 1; model_lock = 3'b000;
    repeat (3) @(negedge clk);
    check("rst_tx_valid", bus.tx_valid, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_error", bus.error, 0);
    check("rst_err_code", bus.err_code, 0);
    check("rst_lock_state", bus.lock_state, 0);
    check("rst_cmd_ack", bus.cmd_ack, 0);
    reset = 1'b0;
    run_txn(1, 8'h00, 0, 8'h04, 0, 0, 0, 0);
    check("lock_latency", last_lat, 6);
    run_txn(0, 8'hF4, 0, 8'h00, 0, 0, 0, 0);
    check("min_latency", last_lat, 3);
    run_txn(0, 8'hF4, 0, 8'h00, 2, 0, 0, 0);
    run_txn(1, 8'h00, 0, 8'h02, 0, 1, 0, 0);
    check("timeout_latency", last_lat, 103);
    fast = 0;
    run_txn(1, 8'h00, 0, 8'h07, 4, 0, 0, 0);
    run_txn(0, 8'hF3, 1, 8'h2B, 1, 0, 3, 0);
    run_txn(1, 8'h00, 0, 8'h01, 0, 0, 4, 0);
    // simultaneous requests, then a second pair raised during the resulting lock transaction
    fast = 1; dones = 0; injected = 0;
    plan_q.delete(); sent_q.delete();
    repeat (8) plan_q.push_back(8'hFA);
    @(negedge clk);
    bus.lock_req = 1'b1; bus.lock_bits = 3'b011;
    bus.cmd_req = 1'b1; bus.cmd_byte = 8'hF4; bus.cmd_has_arg = 1'b0;
    for (int cyc = 0; cyc < 300 && dones < 4; cyc++) begin
      @(negedge clk);
      bus.lock_req = 1'b0;
      if (bus.cmd_ack) bus.cmd_req = 1'b0;
      if (bus.done) dones++;
      if (!injected && bus.tx_valid && bus.tx_data == 8'hED) begin
        injected = 1;
        bus.lock_req = 1'b1; bus.lock_bits = 3'b101;
        bus.cmd_req = 1'b1; bus.cmd_byte = 8'hF5;
      end
    end
    bus.cmd_req = 1'b0;
    check("arb_dones", dones, 4);
    check("arb_len", sent_q.size(), 6);
    if (sent_q.size() == 6) begin
      check("arb_b0", sent_q[0], 8'hF4);
      check("arb_b1", sent_q[1], 8'hED);
      check("arb_b2", sent_q[2], 8'h03);
      check("arb_b3", sent_q[3], 8'hF5);
      check("arb_b4", sent_q[4], 8'hED);
      check("arb_b5", sent_q[5], 8'h05);
    end
    @(negedge clk);
    check("arb_lock_state", bus.lock_state, 3'b101);
    model_lock = 3'b101;
    fast = 0;
    for (int i = 0; i < 24; i++) begin
      bit lk, ha, s0, s1;
      logic [7:0] cb, ag;
      lk = 1'($urandom_range(0, 1)); ha = 1'($urandom_range(0, 1));
      cb = 8'($urandom); ag = 8'($urandom);
      s0 = $urandom_range(0, 9) == 0; s1 = $urandom_range(0, 9) == 0;
      run_txn(lk, cb, ha, ag, $urandom_range(0, 4), s0, $urandom_range(0, 4), s1);
    end
    // reset while waiting for the second byte's ACK, with a lock request pending
    fast = 1;
    plan_q.delete(); sent_q.delete();
    plan_q.push_back(8'hFA); plan_q.push_back(8'h00);
    @(negedge clk);
    bus.lock_req = 1'b1; bus.lock_bits = 3'b110;
    for (int cyc = 0; cyc < 50; cyc++) begin
      @(negedge clk);
      bus.lock_req = 1'b0;
      if (sent_q.size() == 2 && bus.busy && !bus.tx_valid) break;
    end
    check("wait1_reached", sent_q.size(), 2);
    bus.lock_req = 1'b1; bus.lock_bits = 3'b001;
    @(negedge clk);
    bus.lock_req = 1'b0;
    reset = 1'b1;
    #1;
    check("mid_rst_tx_valid", bus.tx_valid, 0);
    check("mid_rst_busy", bus.busy, 0);
    check("mid_rst_done", bus.done, 0);
    check("mid_rst_error", bus.error, 0);
    check("mid_rst_lock_state", bus.lock_state, 0);
    @(negedge clk);
    reset = 1'b0;
    txv = 0;
    repeat (10) begin
      @(negedge clk);
      if (bus.tx_valid || bus.busy || bus.done || bus.error) txv++;
    end
    check("post_rst_idle", txv, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
